// File: rtl/axi_pack_pkg.sv
// Shared definitions for the AXI write beat packer: burst/response codes,
// FSM states and packed-word field offsets.
package axi_pack_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Packed word, MSB to LSB: {last, id, strb, addr, data}
  function automatic int word_width(input int addr_w, input int data_w, input int id_w);
    return 1 + id_w + data_w / 8 + addr_w + data_w;
  endfunction

  function automatic int addr_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int strb_lsb(input int addr_w, input int data_w);
    return data_w + addr_w;
  endfunction

  function automatic int id_lsb(input int addr_w, input int data_w);
    return data_w + addr_w + data_w / 8;
  endfunction

  function automatic int last_bit(input int addr_w, input int data_w, input int id_w);
    return data_w + addr_w + data_w / 8 + id_w;
  endfunction

  localparam int DEF_ADDR_LSB = 16;
  localparam int DEF_STRB_LSB = 48;
  localparam int DEF_ID_LSB   = 50;
  localparam int DEF_LAST_BIT = 56;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for AXI FIXED/INCR/WRAP bursts.
module axi_burst_addr_gen
  import axi_pack_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic                  wrap_ok;

  always_comb begin
    step      = ADDR_WIDTH'(1) << size;
    incr_addr = addr + step;
    wrap_ok   = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    // Window is (len+1) beats of 2^size bytes, aligned to its own size
    wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    next_addr = incr_addr;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP: begin
        if (wrap_ok) next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      end
      default: next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_wr_beat_packer.sv
// AXI write responder that packs each accepted W beat into one FIFO word.
// Optional AXI_WR_PACKER_WLAST_CHECK_EN: flag wlast mismatches with SLVERR.
module axi_wr_beat_packer
  import axi_pack_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 6,
  parameter int WIDTH      = word_width(ADDR_WIDTH, DATA_WIDTH, ID_WIDTH)
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  input  logic [ID_WIDTH-1:0]     awid_i,
  input  logic [ADDR_WIDTH-1:0]   awaddr_i,
  input  logic [7:0]              awlen_i,
  input  logic [2:0]              awsize_i,
  input  logic [1:0]              awburst_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic                    wlast_i,
  output logic                    bvalid_o,
  input  logic                    bready_i,
  output logic [ID_WIDTH-1:0]     bid_o,
  output logic [1:0]              bresp_o,
  output logic                    fifo_wr_req_o,
  output logic [WIDTH-1:0]        fifo_wr_data_o,
  input  logic                    fifo_wr_ready_i
);

  localparam int A_LSB = addr_lsb(DATA_WIDTH);
  localparam int S_LSB = strb_lsb(ADDR_WIDTH, DATA_WIDTH);
  localparam int I_LSB = id_lsb(ADDR_WIDTH, DATA_WIDTH);
  localparam int L_BIT = last_bit(ADDR_WIDTH, DATA_WIDTH, ID_WIDTH);

  state_t                state_q, state_d;
  logic                  live_q;
  logic [7:0]            cnt_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [WIDTH-1:0]      word;
  logic [1:0]            resp_code;
  logic                  aw_hs;
  logic                  beat;
  logic                  last;

  assign aw_hs = awvalid_i & awready_o;
  assign beat  = fifo_wr_req_o;
  assign last  = (cnt_q == len_q);

  axi_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  // live_q holds awready low until the first clock after reset release
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      live_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      if (aw_hs)     cnt_q <= 8'd0;
      else if (beat) cnt_q <= cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (aw_hs) begin
      id_q    <= awid_i;
      addr_q  <= awaddr_i;
      len_q   <= awlen_i;
      size_q  <= awsize_i;
      burst_q <= awburst_i;
    end else if (beat) begin
      addr_q  <= next_addr;
    end
  end

`ifdef AXI_WR_PACKER_WLAST_CHECK_EN
  logic err_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                    err_q <= 1'b0;
    else if (aw_hs)                  err_q <= 1'b0;
    else if (beat && (wlast_i != last)) err_q <= 1'b1;
  end

  assign resp_code = err_q ? RESP_SLVERR : RESP_OKAY;
`else
  logic unused_wlast;

  assign unused_wlast = wlast_i;
  assign resp_code    = RESP_OKAY;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (aw_hs)          state_d = ST_DATA;
      ST_DATA: if (beat && last)   state_d = ST_RESP;
      ST_RESP: if (bready_i)       state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    word                 = '0;
    word[A_LSB-1:0]      = wdata_i;
    word[S_LSB-1:A_LSB]  = addr_q;
    word[I_LSB-1:S_LSB]  = wstrb_i;
    word[L_BIT-1:I_LSB]  = id_q;
    word[L_BIT]          = last;
  end

  // Write strobe is gated by fifo_wr_ready_i: the FIFO has no overflow guard
  always_comb begin
    awready_o      = (state_q == ST_IDLE) & live_q;
    wready_o       = (state_q == ST_DATA) & fifo_wr_ready_i;
    fifo_wr_req_o  = (state_q == ST_DATA) & wvalid_i & fifo_wr_ready_i;
    fifo_wr_data_o = fifo_wr_req_o ? word : '0;
    bvalid_o       = (state_q == ST_RESP);
    bid_o          = (state_q == ST_RESP) ? id_q : '0;
    bresp_o        = (state_q == ST_RESP) ? resp_code : RESP_OKAY;
  end

endmodule

// File: tb/tb_axi_wr_beat_packer.sv
// Directed bench for axi_wr_beat_packer: INCR/WRAP/FIXED bursts, stalls,
// 256-beat burst, wlast mismatch and mid-burst reset.
module tb_axi_wr_beat_packer;

  localparam int AW = 32;
  localparam int DW = 16;
  localparam int IW = 6;
  localparam int SW = 2;
  localparam int WW = 57;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          awvalid = 1'b0;
  logic          awready_o;
  logic [IW-1:0] awid = '0;
  logic [AW-1:0] awaddr = '0;
  logic [7:0]    awlen = '0;
  logic [2:0]    awsize = '0;
  logic [1:0]    awburst = '0;
  logic          wvalid = 1'b0;
  logic          wready_o;
  logic [DW-1:0] wdata = '0;
  logic [SW-1:0] wstrb = '0;
  logic          wlast = 1'b0;
  logic          bvalid_o;
  logic          bready = 1'b0;
  logic [IW-1:0] bid_o;
  logic [1:0]    bresp_o;
  logic          fifo_wr_req_o;
  logic [WW-1:0] fifo_wr_data_o;
  logic          fifo_ready = 1'b1;

  int checks = 0;
  int errors = 0;
  int nwords = 0;
  int n0;

  axi_wr_beat_packer dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .awvalid_i       (awvalid),
    .awready_o       (awready_o),
    .awid_i          (awid),
    .awaddr_i        (awaddr),
    .awlen_i         (awlen),
    .awsize_i        (awsize),
    .awburst_i       (awburst),
    .wvalid_i        (wvalid),
    .wready_o        (wready_o),
    .wdata_i         (wdata),
    .wstrb_i         (wstrb),
    .wlast_i         (wlast),
    .bvalid_o        (bvalid_o),
    .bready_i        (bready),
    .bid_o           (bid_o),
    .bresp_o         (bresp_o),
    .fifo_wr_req_o   (fifo_wr_req_o),
    .fifo_wr_data_o  (fifo_wr_data_o),
    .fifo_wr_ready_i (fifo_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (fifo_wr_req_o) nwords <= nwords + 1;

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [WW-1:0] mkword(input logic lst, input logic [IW-1:0] id,
                                           input logic [SW-1:0] s, input logic [AW-1:0] a,
                                           input logic [DW-1:0] d);
    return {lst, id, s, a, d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge
  task automatic do_aw(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                       input logic [2:0] sz, input logic [1:0] bu, input string tag);
    chk({tag, ".awready"}, awready_o, 1);
    awvalid = 1'b1; awid = id; awaddr = a; awlen = len; awsize = sz; awburst = bu;
    @(posedge clk); #1;
    awvalid = 1'b0;
    chk({tag, ".awready_data"}, awready_o, 0);
    chk({tag, ".wready_n1"}, wready_o, fifo_ready);
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic wl,
                      input logic [IW-1:0] id, input logic [AW-1:0] a, input logic lst,
                      input string tag);
    wvalid = 1'b1; wdata = d; wstrb = s; wlast = wl;
    #1;
    chk({tag, ".wready"}, wready_o, 1);
    chk({tag, ".req"}, fifo_wr_req_o, 1);
    chk({tag, ".word"}, fifo_wr_data_o, mkword(lst, id, s, a, d));
    @(posedge clk); #1;
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic resp(input logic [IW-1:0] id, input logic [1:0] rc, input int hold,
                      input string tag);
    chk({tag, ".bvalid"}, bvalid_o, 1);
    chk({tag, ".bid"}, bid_o, id);
    chk({tag, ".bresp"}, bresp_o, rc);
    chk({tag, ".wready_resp"}, wready_o, 0);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk({tag, ".bvalid_hold"}, bvalid_o, 1);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk({tag, ".bvalid_done"}, bvalid_o, 0);
    chk({tag, ".awready_after"}, awready_o, 1);
  endtask

  initial begin
    // Reset values
    #2;
    chk("rst.awready", awready_o, 0);
    chk("rst.wready", wready_o, 0);
    chk("rst.bvalid", bvalid_o, 0);
    chk("rst.bid", bid_o, 0);
    chk("rst.bresp", bresp_o, 0);
    chk("rst.req", fifo_wr_req_o, 0);
    chk("rst.data", fifo_wr_data_o, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle.awready", awready_o, 1);

    // W ignored in IDLE
    wvalid = 1'b1; #1;
    chk("idle.wready", wready_o, 0);
    chk("idle.req", fifo_wr_req_o, 0);
    @(posedge clk); #1;
    wvalid = 1'b0;

    // INCR 0x1000, len 3, size 1
    n0 = nwords;
    do_aw(6'd5, 32'h1000, 8'd3, 3'd1, 2'd1, "incr");
    beat(16'hA000, 2'b11, 1'b0, 6'd5, 32'h1000, 1'b0, "incr.b0");
    beat(16'hA001, 2'b01, 1'b0, 6'd5, 32'h1002, 1'b0, "incr.b1");
    beat(16'hA002, 2'b10, 1'b0, 6'd5, 32'h1004, 1'b0, "incr.b2");
    beat(16'hA003, 2'b11, 1'b1, 6'd5, 32'h1006, 1'b1, "incr.b3");
    resp(6'd5, 2'd0, 2, "incr");
    chk("incr.nwords", nwords - n0, 4);

    // WRAP 0x1006, len 3, size 1
    n0 = nwords;
    do_aw(6'h2A, 32'h1006, 8'd3, 3'd1, 2'd2, "wrap");
    beat(16'h1111, 2'b11, 1'b0, 6'h2A, 32'h1006, 1'b0, "wrap.b0");
    beat(16'h2222, 2'b11, 1'b0, 6'h2A, 32'h1000, 1'b0, "wrap.b1");
    beat(16'h3333, 2'b11, 1'b0, 6'h2A, 32'h1002, 1'b0, "wrap.b2");
    beat(16'h4444, 2'b11, 1'b1, 6'h2A, 32'h1004, 1'b1, "wrap.b3");
    resp(6'h2A, 2'd0, 0, "wrap");
    chk("wrap.nwords", nwords - n0, 4);

    // FIXED 0x20, len 2, FIFO not ready for 3 cycles mid-burst
    n0 = nwords;
    do_aw(6'd7, 32'h20, 8'd2, 3'd1, 2'd0, "fixed");
    beat(16'hBEE0, 2'b11, 1'b0, 6'd7, 32'h20, 1'b0, "fixed.b0");
    wvalid = 1'b1; wdata = 16'hBEE1; wstrb = 2'b11; fifo_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("fixed.stall_wready", wready_o, 0);
      chk("fixed.stall_req", fifo_wr_req_o, 0);
      @(posedge clk); #1;
    end
    fifo_ready = 1'b1;
    beat(16'hBEE1, 2'b11, 1'b0, 6'd7, 32'h20, 1'b0, "fixed.b1");
    beat(16'hBEE2, 2'b11, 1'b1, 6'd7, 32'h20, 1'b1, "fixed.b2");
    resp(6'd7, 2'd0, 0, "fixed");
    chk("fixed.nwords", nwords - n0, 3);

    // INCR len 255: 256 beats
    n0 = nwords;
    do_aw(6'd1, 32'h0, 8'd255, 3'd1, 2'd1, "long");
    for (int i = 0; i < 256; i++)
      beat(DW'(i * 3), 2'b11, (i == 255), 6'd1, AW'(i * 2), (i == 255),
           $sformatf("long.b%0d", i));
    resp(6'd1, 2'd0, 0, "long");
    chk("long.nwords", nwords - n0, 256);

    // wlast asserted early on beat 1 of a len-3 burst
    n0 = nwords;
    do_aw(6'd12, 32'h40, 8'd3, 3'd1, 2'd1, "wl");
    beat(16'h0C00, 2'b11, 1'b0, 6'd12, 32'h40, 1'b0, "wl.b0");
    beat(16'h0C01, 2'b11, 1'b1, 6'd12, 32'h42, 1'b0, "wl.b1");
    beat(16'h0C02, 2'b11, 1'b0, 6'd12, 32'h44, 1'b0, "wl.b2");
    beat(16'h0C03, 2'b11, 1'b1, 6'd12, 32'h46, 1'b1, "wl.b3");
`ifdef AXI_WR_PACKER_WLAST_CHECK_EN
    resp(6'd12, 2'd2, 0, "wl");
`else
    resp(6'd12, 2'd0, 0, "wl");
`endif
    chk("wl.nwords", nwords - n0, 4);

    // Reset after beat 2 of a len-7 burst
    do_aw(6'd3, 32'h100, 8'd7, 3'd1, 2'd1, "rstb");
    beat(16'h5550, 2'b11, 1'b0, 6'd3, 32'h100, 1'b0, "rstb.b0");
    beat(16'h5551, 2'b11, 1'b0, 6'd3, 32'h102, 1'b0, "rstb.b1");
    wvalid = 1'b1; wdata = 16'h5552;
    rst_n = 1'b0;
    #1;
    chk("rstb.awready", awready_o, 0);
    chk("rstb.wready", wready_o, 0);
    chk("rstb.req", fifo_wr_req_o, 0);
    chk("rstb.data", fifo_wr_data_o, 0);
    chk("rstb.bvalid", bvalid_o, 0);
    wvalid = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rstb.bvalid_after", bvalid_o, 0);
    n0 = nwords;
    do_aw(6'd9, 32'h200, 8'd0, 3'd1, 2'd1, "post");
    beat(16'h9999, 2'b11, 1'b1, 6'd9, 32'h200, 1'b1, "post.b0");
    resp(6'd9, 2'd0, 0, "post");
    chk("post.nwords", nwords - n0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
